// File: rtl/calc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared key codes, FSM state encodings and key-classification
//            helpers for the calculator keypad sequencer.
// Contents : KEY_ADD..KEY_DIV (operators), KEY_EQ, KEY_CLR,
//            S_A / S_B / S_WAIT / S_RES (2-bit state encodings),
//            is_digit(), is_op().
// Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [1:0] S_A    = 2'd0;  // entering operand A
    localparam logic [1:0] S_B    = 2'd1;  // entering operand B
    localparam logic [1:0] S_WAIT = 2'd2;  // waiting for arithmetic unit
    localparam logic [1:0] S_RES  = 2'd3;  // result displayed

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_key_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calc_key_seq_if
// Purpose  : Key-input and arithmetic-unit handshake bundle of the keypad
//            sequencer.
// Signals  : key_value / flag        decoded key and its one-cycle strobe
//            num_result / calc_ack   result from arithmetic unit + valid
//            calc_req / busy         request to arithmetic unit, busy flag
// Modports : master (environment side), slave (sequencer side)
// Revision : 1.0  initial release
// ============================================================================
interface calc_key_seq_if #(
    parameter int NW = 24
);
    logic [3:0]    key_value;
    logic          flag;
    logic [NW-1:0] num_result;
    logic          calc_ack;
    logic          calc_req;
    logic          busy;

    modport master (
        output key_value, flag, num_result, calc_ack,
        input  calc_req, busy
    );

    modport slave (
        input  key_value, flag, num_result, calc_ack,
        output calc_req, busy
    );
endinterface
`default_nettype wire

// File: rtl/calc_bcd_shreg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calc_bcd_shreg
// Purpose  : One BCD operand register with a saturating digit counter.
//            Supports clear, parallel load, digit shift-in (dropped once
//            DIGITS digits are held) and backspace (shift right one digit).
// Ports    : clk, rst            clock, synchronous active-high reset
//            i_clr               zero value and counter
//            i_load/_val/_cnt    parallel load of value and counter
//            i_shift, i_digit    append a digit at the least significant end
//            i_bksp              remove least significant digit
//            o_val, o_cnt        operand value and digit count
// Priority : rst > i_clr > i_load > i_shift > i_bksp
// Revision : 1.0  initial release
// ============================================================================
module calc_bcd_shreg #(
    parameter int DIGITS = 6,
    parameter int CW     = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_clr,
    input  wire logic                  i_load,
    input  wire logic [4*DIGITS-1:0]   i_load_val,
    input  wire logic [CW-1:0]         i_load_cnt,
    input  wire logic                  i_shift,
    input  wire logic [3:0]            i_digit,
    input  wire logic                  i_bksp,
    output logic      [4*DIGITS-1:0]   o_val,
    output logic      [CW-1:0]         o_cnt
);
    localparam int           c_NW      = 4 * DIGITS;
    localparam logic [CW-1:0] c_MAX_CNT = CW'(DIGITS);

    logic [c_NW-1:0] r_val;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_val <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_val <= i_load_val;
            r_cnt <= i_load_cnt;
        end else if (i_shift) begin
            // A full operand silently drops further digits.
            if (r_cnt != c_MAX_CNT) begin
                r_val <= {r_val[c_NW-5:0], i_digit};
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_bksp) begin
            if (r_cnt != '0) begin
                r_val <= {4'h0, r_val[c_NW-1:4]};
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_val = r_val;
    assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/calc_key_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : calc_key_seq
// Purpose  : Keypad-entry sequencer. Builds BCD operands A and B from key
//            pulses, latches the operator, requests a calculation on '='
//            and supports chaining on the returned result.
// Ports    : CLK_1K, RST         clock, synchronous active-high reset
//            bus (slave)         key_value/flag in, num_result/calc_ack in,
//                                calc_req/busy out
//            num_reg1, num_reg2  operands A and B (BCD)
//            opcode              latched operator (0 = none)
//            num_out             display value
//            cnt1, cnt2          digit counts of A and B
//            state_now           FSM state (S_A/S_B/S_WAIT/S_RES)
// Config   : CALC_BKSP_EN - key F with a non-empty active operand in S_A/S_B
//            removes the last digit instead of clearing everything.
// Revision : 1.0  initial release
// ============================================================================
module calc_key_seq
    import calc_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int OPW    = 4,
    parameter int CW     = 3
) (
    input  wire logic                 CLK_1K,
    input  wire logic                 RST,
    calc_key_seq_if.slave             bus,
    output logic      [4*DIGITS-1:0]  num_reg1,
    output logic      [4*DIGITS-1:0]  num_reg2,
    output logic      [OPW-1:0]       opcode,
    output logic      [4*DIGITS-1:0]  num_out,
    output logic      [CW-1:0]        cnt1,
    output logic      [CW-1:0]        cnt2,
    output logic      [1:0]           state_now
);
    localparam int            c_NW      = 4 * DIGITS;
    localparam logic [CW-1:0] c_MAX_CNT = CW'(DIGITS);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [OPW-1:0]  r_opcode;

    logic            w_is_digit;
    logic            w_is_op;
    logic            w_is_eq;
    logic            w_is_clr;

    logic            w_clr_all;
    logic            w_a_shift;
    logic            w_a_bksp;
    logic            w_a_load;
    logic [c_NW-1:0] w_a_load_val;
    logic [CW-1:0]   w_a_load_cnt;
    logic            w_b_shift;
    logic            w_b_bksp;
    logic            w_b_clr;
    logic            w_op_set;
    logic            w_op_clr;

    // Key classification is qualified by flag so every decode below acts
    // only on press cycles.
    assign w_is_digit = bus.flag && is_digit(bus.key_value);
    assign w_is_op    = bus.flag && is_op(bus.key_value);
    assign w_is_eq    = bus.flag && (bus.key_value == KEY_EQ);
    assign w_is_clr   = bus.flag && (bus.key_value == KEY_CLR);

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK_1K) begin
        if (RST) r_state <= S_A;
        else     r_state <= w_state_nxt;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_A: begin
                if (w_is_op) w_state_nxt = S_B;
            end
            S_B: begin
                if (w_is_eq && (cnt2 != '0)) w_state_nxt = S_WAIT;
`ifdef CALC_BKSP_EN
                else if (w_is_clr && (cnt2 == '0)) w_state_nxt = S_A;
`else
                else if (w_is_clr) w_state_nxt = S_A;
`endif
            end
            S_WAIT: begin
                if (bus.calc_ack) w_state_nxt = S_RES;
            end
            S_RES: begin
                if (w_is_digit || w_is_clr) w_state_nxt = S_A;
                else if (w_is_op)           w_state_nxt = S_B;
            end
            default: w_state_nxt = S_A;
        endcase
    end

    // ------------------------------------------------------ datapath strobes
    always_comb begin
        w_clr_all    = 1'b0;
        w_a_shift    = 1'b0;
        w_a_bksp     = 1'b0;
        w_a_load     = 1'b0;
        w_a_load_val = '0;
        w_a_load_cnt = '0;
        w_b_shift    = 1'b0;
        w_b_bksp     = 1'b0;
        w_b_clr      = 1'b0;
        w_op_set     = 1'b0;
        w_op_clr     = 1'b0;
        case (r_state)
            S_A: begin
                if (w_is_digit) w_a_shift = 1'b1;
                if (w_is_op)    w_op_set  = 1'b1;
`ifdef CALC_BKSP_EN
                if (w_is_clr) begin
                    if (cnt1 != '0) w_a_bksp  = 1'b1;
                    else            w_clr_all = 1'b1;
                end
`else
                if (w_is_clr) w_clr_all = 1'b1;
`endif
            end
            S_B: begin
                // Operator replacement only until B's first digit.
                if (w_is_op && (cnt2 == '0)) w_op_set  = 1'b1;
                if (w_is_digit)              w_b_shift = 1'b1;
`ifdef CALC_BKSP_EN
                if (w_is_clr) begin
                    if (cnt2 != '0) w_b_bksp  = 1'b1;
                    else            w_clr_all = 1'b1;
                end
`else
                if (w_is_clr) w_clr_all = 1'b1;
`endif
            end
            S_WAIT: begin
                // Result becomes operand A, reported as a full operand.
                if (bus.calc_ack) begin
                    w_a_load     = 1'b1;
                    w_a_load_val = bus.num_result;
                    w_a_load_cnt = c_MAX_CNT;
                    w_b_clr      = 1'b1;
                end
            end
            S_RES: begin
                if (w_is_digit) begin
                    w_a_load     = 1'b1;
                    w_a_load_val = c_NW'(bus.key_value);
                    w_a_load_cnt = CW'(1);
                    w_op_clr     = 1'b1;
                end
                if (w_is_op)  w_op_set  = 1'b1;
                if (w_is_clr) w_clr_all = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ operator latch
    always_ff @(posedge CLK_1K) begin
        if (RST || w_clr_all || w_op_clr) r_opcode <= '0;
        else if (w_op_set)                r_opcode <= OPW'(bus.key_value);
    end

    calc_bcd_shreg #(.DIGITS(DIGITS), .CW(CW)) u_reg_a (
        .clk        (CLK_1K),
        .rst        (RST),
        .i_clr      (w_clr_all),
        .i_load     (w_a_load),
        .i_load_val (w_a_load_val),
        .i_load_cnt (w_a_load_cnt),
        .i_shift    (w_a_shift),
        .i_digit    (bus.key_value),
        .i_bksp     (w_a_bksp),
        .o_val      (num_reg1),
        .o_cnt      (cnt1)
    );

    calc_bcd_shreg #(.DIGITS(DIGITS), .CW(CW)) u_reg_b (
        .clk        (CLK_1K),
        .rst        (RST),
        .i_clr      (w_clr_all || w_b_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_load_cnt ('0),
        .i_shift    (w_b_shift),
        .i_digit    (bus.key_value),
        .i_bksp     (w_b_bksp),
        .o_val      (num_reg2),
        .o_cnt      (cnt2)
    );

    assign opcode       = r_opcode;
    assign state_now    = r_state;
    assign bus.calc_req = (r_state == S_WAIT);
    assign bus.busy     = (r_state == S_WAIT);
    // Show B once it has a digit, otherwise A (or the result).
    assign num_out      = ((r_state == S_B) && (cnt2 != '0)) ? num_reg2 : num_reg1;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_calc_key_seq
// Purpose  : Self-checking bench for calc_key_seq: directed scenarios then
//            random key/ack traffic compared against a digit-list model.
// Config   : follows CALC_BKSP_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_key_seq;
    localparam int DIGITS = 6;
    localparam int OPW    = 4;
    localparam int CW     = 3;
    localparam int NW     = 4 * DIGITS;
`ifdef CALC_BKSP_EN
    localparam bit BKSP = 1'b1;
`else
    localparam bit BKSP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] num_reg1, num_reg2, num_out;
    logic [OPW-1:0] opcode;
    logic [CW-1:0] cnt1, cnt2;
    logic [1:0]    state_now;

    always #5 clk = ~clk;

    calc_key_seq_if #(.NW(NW)) bus ();

    calc_key_seq #(.DIGITS(DIGITS), .OPW(OPW), .CW(CW)) dut (
        .CLK_1K    (clk),
        .RST       (rst),
        .bus       (bus),
        .num_reg1  (num_reg1),
        .num_reg2  (num_reg2),
        .opcode    (opcode),
        .num_out   (num_out),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .state_now (state_now)
    );

    // Model: operands as lists of digits (oldest first); state 0=A 1=B 2=WAIT 3=RES
    int qa[$];
    int qb[$];
    int m_st;
    int m_op;
    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [NW-1:0] val_a();
        logic [NW-1:0] v = '0;
        foreach (qa[i]) v = v * 16 + NW'(qa[i]);
        return v;
    endfunction

    function automatic logic [NW-1:0] val_b();
        logic [NW-1:0] v = '0;
        foreach (qb[i]) v = v * 16 + NW'(qb[i]);
        return v;
    endfunction

    task automatic m_clear();
        qa.delete(); qb.delete(); m_op = 0; m_st = 0;
    endtask

    task automatic m_key(input int k);
        case (m_st)
            0: begin
                if (k <= 9) begin
                    if (qa.size() < DIGITS) qa.push_back(k);
                end else if (k >= 10 && k <= 13) begin
                    m_op = k; m_st = 1;
                end else if (k == 15) begin
                    if (BKSP && qa.size() > 0) void'(qa.pop_back());
                    else m_clear();
                end
            end
            1: begin
                if (k <= 9) begin
                    if (qb.size() < DIGITS) qb.push_back(k);
                end else if (k >= 10 && k <= 13) begin
                    if (qb.size() == 0) m_op = k;
                end else if (k == 14) begin
                    if (qb.size() > 0) m_st = 2;
                end else begin
                    if (BKSP && qb.size() > 0) void'(qb.pop_back());
                    else m_clear();
                end
            end
            3: begin
                if (k <= 9) begin
                    qa.delete(); qa.push_back(k); m_op = 0; m_st = 0;
                end else if (k >= 10 && k <= 13) begin
                    m_op = k; m_st = 1;
                end else if (k == 15) begin
                    m_clear();
                end
            end
            default: ;
        endcase
    endtask

    task automatic m_ack(input logic [NW-1:0] r);
        qa.delete();
        for (int i = DIGITS - 1; i >= 0; i--) qa.push_back(int'((r >> (4 * i)) & 'hF));
        qb.delete();
        m_st = 3;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [NW-1:0] e_out;
        e_out = (m_st == 1 && qb.size() != 0) ? val_b() : val_a();
        chk({tag, ".num_reg1"}, 64'(num_reg1), 64'(val_a()));
        chk({tag, ".num_reg2"}, 64'(num_reg2), 64'(val_b()));
        chk({tag, ".cnt1"}, 64'(cnt1), 64'(qa.size()));
        chk({tag, ".cnt2"}, 64'(cnt2), 64'(qb.size()));
        chk({tag, ".opcode"}, 64'(opcode), 64'(m_op));
        chk({tag, ".state"}, 64'(state_now), 64'(m_st));
        chk({tag, ".calc_req"}, 64'(bus.calc_req), 64'(m_st == 2));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(m_st == 2));
        chk({tag, ".num_out"}, 64'(num_out), 64'(e_out));
    endtask

    // One clock of stimulus, model update, then a full output check.
    task automatic step(input string tag, input bit f, input int k, input bit a, input logic [NW-1:0] r);
        @(negedge clk);
        bus.flag = f; bus.key_value = 4'(k); bus.calc_ack = a; bus.num_result = r;
        @(posedge clk);
        if (m_st == 2) begin
            if (a) m_ack(r);
        end else if (f) begin
            m_key(k);
        end
        #1;
        bus.flag = 1'b0; bus.calc_ack = 1'b0;
        check_all(tag);
    endtask

    task automatic press(input string tag, input int k);
        step(tag, 1'b1, k, 1'b0, '0);
    endtask

    task automatic ack(input string tag, input logic [NW-1:0] r);
        step(tag, 1'b0, 0, 1'b1, r);
    endtask

    // Reset asserted together with a key and an ack: reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; bus.flag = 1'b1; bus.key_value = 4'h1; bus.calc_ack = 1'b1;
        @(posedge clk);
        m_clear();
        #1;
        rst = 1'b0; bus.flag = 1'b0; bus.calc_ack = 1'b0;
        check_all(tag);
    endtask

    function automatic logic [NW-1:0] rand_bcd();
        logic [NW-1:0] v = '0;
        for (int i = 0; i < DIGITS; i++) v = (v << 4) | NW'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        rst = 1'b1; bus.flag = 1'b0; bus.key_value = '0; bus.calc_ack = 1'b0; bus.num_result = '0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");

        // Basic calculation 12 + 3 = 15
        press("t1.k1", 1); press("t1.k2", 2); press("t1.add", 'hA); press("t1.k3", 3);
        press("t1.eq", 'hE);
        step("t1.idle", 1'b0, 0, 1'b0, '0);
        step("t1.idle", 1'b0, 0, 1'b0, '0);
        ack("t1.ack", 24'h000015);
        chk("t1.res_val", 64'(num_reg1), 64'h15);
        chk("t1.res_state", 64'(state_now), 64'd3);

        // Chain on result: - 4 =
        press("t2.sub", 'hB); press("t2.k4", 4); press("t2.eq", 'hE);
        ack("t2.ack", 24'h000011);
        chk("t2.opcode", 64'(opcode), 64'hB);
        chk("t2.res_val", 64'(num_reg1), 64'h11);

        // Seven digits into A: last one dropped
        do_reset("t3.rst");
        for (int i = 1; i <= 7; i++) press("t3.dig", i);
        chk("t3.sat_val", 64'(num_reg1), 64'h123456);
        chk("t3.sat_cnt", 64'(cnt1), 64'd6);

        // Operator replacement; '=' with empty B ignored
        do_reset("t4.rst");
        press("t4.k5", 5); press("t4.add", 'hA); press("t4.mul", 'hC); press("t4.eq", 'hE);
        chk("t4.no_req", 64'(bus.calc_req), 64'd0);
        press("t4.k2", 2);
        chk("t4.opcode", 64'(opcode), 64'hC);

        // Keys during WAIT ignored; ack beats a simultaneous key
        press("t5.eq", 'hE);
        press("t5.dig_wait", 3);
        press("t5.clr_wait", 'hF);
        step("t5.ack_key", 1'b1, 1, 1'b1, 24'h000010);
        chk("t5.ack_state", 64'(state_now), 64'd3);
        press("t5.new_dig", 8);
        press("t5.add", 'hA); press("t5.k1", 1); press("t5.eq", 'hE);
        do_reset("t5.rst_wait");

        // F after three digits: backspace or full clear depending on build
        press("t6.k1", 1); press("t6.k2", 2); press("t6.k3", 3); press("t6.f", 'hF);
        chk("t6.f_val", 64'(num_reg1), BKSP ? 64'h12 : 64'h0);
        chk("t6.f_cnt", 64'(cnt1), BKSP ? 64'd2 : 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int k;
            bit f, a;
            k = int'($urandom_range(0, 15));
            if (k == 15 && $urandom_range(0, 2) != 0) k = int'($urandom_range(0, 9));
            f = ($urandom_range(0, 3) != 0);
            a = (m_st == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) do_reset("rnd.rst");
            else step("rnd", f, k, a, rand_bcd());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
